ram1_port_arbiter: RTL

- Shares port A of the ram1 dual-port 4096x8 memory between the chip8 CPU and one auxiliary requester (display scanner / program loader).
- CPU has fixed priority.
- A starvation counter guarantees the auxiliary requester a slot.
- Tracks the RAM's read latency and returns read data with a valid strobe to whichever requester issued the read.

---
 rtl/ram1_port_arbiter_if.sv | 51 +++++
 rtl/ram1_port_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/ram1_port_arbiter_if.sv
// Port-A bus of the ram1 arbiter: CPU and aux request bundles, the RAM side
// and the arbiter's debug view. "slave" is the arbiter, "master" is everyone else.
interface ram1_port_arbiter_if;
  // Handshake: a requester holds req with we/addr/wdata stable; the access
  // happens in the cycle gnt is high (combinational, same cycle). A read's
  // data comes back later as a one-cycle rvalid pulse with rdata alongside.
  logic        cpu_req;
  logic        cpu_we;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_lock;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;

  logic        aux_req;
  logic        aux_we;
  logic [11:0] aux_addr;
  logic [7:0]  aux_wdata;
  logic        aux_gnt;
  logic        aux_rvalid;
  logic [7:0]  aux_rdata;

  logic [11:0] ram_address;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic [7:0]  ram_q;

  logic [3:0]  dbg_aux_wait;
  logic        dbg_lock_pending;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    output aux_gnt, aux_rvalid, aux_rdata,
    output ram_address, ram_data, ram_wren,
    input  ram_q,
    output dbg_aux_wait, dbg_lock_pending
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output aux_req, aux_we, aux_addr, aux_wdata,
    input  aux_gnt, aux_rvalid, aux_rdata,
    input  ram_address, ram_data, ram_wren,
    output ram_q,
    input  dbg_aux_wait, dbg_lock_pending
  );
endinterface

// File: rtl/ram1_port_arbiter.sv
// Shares ram1 port A between the chip8 CPU (fixed priority, optional one-cycle
// lock) and an aux requester protected by a starvation counter.
module ram1_port_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int MAX_WAIT     = 4
) (
  input logic CLOCK_50,
  input logic rst_n,
  ram1_port_arbiter_if.slave bus
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic                    lock_pending;
  logic [3:0]              aux_wait;
  logic                    starve;
  logic                    cpu_gnt;
  logic                    aux_gnt;
  logic                    rd_issue;
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [READ_LATENCY-1:0] pipe_cpu;
  logic                    cpu_rvalid;
  logic                    aux_rvalid;
  logic [7:0]              cpu_hold;
  logic [7:0]              aux_hold;

  assign starve = (aux_wait >= WAIT_LIMIT);

  // Grants are forced low while reset is asserted so the RAM sees no access.
  always_comb begin
    cpu_gnt = 1'b0;
    aux_gnt = 1'b0;
    if (rst_n) begin
      if (lock_pending && bus.cpu_req)  cpu_gnt = 1'b1;
      else if (starve && bus.aux_req)   aux_gnt = 1'b1;
      else if (bus.cpu_req)             cpu_gnt = 1'b1;
      else if (bus.aux_req)             aux_gnt = 1'b1;
    end
  end

  always_comb begin
    bus.ram_address = '0;
    bus.ram_data    = '0;
    bus.ram_wren    = 1'b0;
    if (cpu_gnt) begin
      bus.ram_address = bus.cpu_addr;
      bus.ram_data    = bus.cpu_wdata;
      bus.ram_wren    = bus.cpu_we;
    end else if (aux_gnt) begin
      bus.ram_address = bus.aux_addr;
      bus.ram_data    = bus.aux_wdata;
      bus.ram_wren    = bus.aux_we;
    end
  end

  assign rd_issue = (cpu_gnt && !bus.cpu_we) || (aux_gnt && !bus.aux_we);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      lock_pending <= 1'b0;
      aux_wait     <= '0;
      pipe_valid   <= '0;
      pipe_cpu     <= '0;
      cpu_hold     <= '0;
      aux_hold     <= '0;
    end else begin
      // Set only from a non-lock grant, so a held cpu_lock cannot chain.
      lock_pending <= cpu_gnt && bus.cpu_lock && !lock_pending;

      if (bus.aux_req && !aux_gnt)
        aux_wait <= (aux_wait == 4'hF) ? aux_wait : aux_wait + 4'd1;
      else
        aux_wait <= '0;

      pipe_valid[0] <= rd_issue;
      pipe_cpu[0]   <= cpu_gnt;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_cpu[i]   <= pipe_cpu[i-1];
      end

      if (cpu_rvalid) cpu_hold <= bus.ram_q;
      if (aux_rvalid) aux_hold <= bus.ram_q;
    end
  end

  assign cpu_rvalid = pipe_valid[READ_LATENCY-1] &&  pipe_cpu[READ_LATENCY-1];
  assign aux_rvalid = pipe_valid[READ_LATENCY-1] && !pipe_cpu[READ_LATENCY-1];

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.aux_gnt    = aux_gnt;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.aux_rvalid = aux_rvalid;
  assign bus.cpu_rdata  = cpu_rvalid ? bus.ram_q : cpu_hold;
  assign bus.aux_rdata  = aux_rvalid ? bus.ram_q : aux_hold;

  assign bus.dbg_aux_wait     = aux_wait;
  assign bus.dbg_lock_pending = lock_pending;

endmodule
